// File: rtl/ycc_bitstream_merge.sv
// Buffers Y/Cb/Cr JPEG bitstream words in per-channel FIFOs and
// merges them onto one stream in Y, Cb, Cr block order.
module ycc_bitstream_merge #(
    parameter int DEPTH = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] y_bitstream,
    input  logic        y_data_ready,
    input  logic        y_block_end,
    input  logic [4:0]  y_orc,
    input  logic [31:0] cb_bitstream,
    input  logic        cb_data_ready,
    input  logic        cb_block_end,
    input  logic [4:0]  cb_orc,
    input  logic [31:0] cr_bitstream,
    input  logic        cr_data_ready,
    input  logic        cr_block_end,
    input  logic [4:0]  cr_orc,
    output logic [31:0] out_bitstream,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        out_eob,
    output logic [4:0]  out_orc,
    output logic [1:0]  out_channel,
    output logic [2:0]  overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    typedef enum logic [1:0] {
        SEL_Y  = 2'd0,
        SEL_CB = 2'd1,
        SEL_CR = 2'd2
    } sel_t;

    sel_t state, state_nxt;

    logic [2:0][31:0] in_data;
    logic [2:0][4:0]  in_orc;
    logic [2:0]       in_dr, in_be;
    logic [2:0][37:0] heads;
    logic [2:0][AW:0] cnts;
    logic [2:0]       wr, rd, sel_oh;
    logic [37:0]      head;
    logic [AW:0]      sel_cnt;

    assign in_data = {cr_bitstream, cb_bitstream, y_bitstream};
    assign in_orc  = {cr_orc, cb_orc, y_orc};
    assign in_dr   = {cr_data_ready, cb_data_ready, y_data_ready};
    assign in_be   = {cr_block_end, cb_block_end, y_block_end};

    for (genvar c = 0; c < 3; c++) begin : g_ch
        logic [37:0]   mem [DEPTH];
        logic [AW-1:0] wr_ptr, rd_ptr;
        logic [AW:0]   cnt;

        assign rd[c]    = sel_oh[c] & out_valid & out_ready;
        // A full FIFO still accepts a word when it is read on the same edge
        assign wr[c]    = in_dr[c] & ((cnt != FULL) | rd[c]);
        assign heads[c] = mem[rd_ptr];
        assign cnts[c]  = cnt;

        always_ff @(posedge clk) begin
            if (wr[c])
                mem[wr_ptr] <= {in_be[c], in_be[c] ? in_orc[c] : 5'd0, in_data[c]};
        end

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                cnt    <= '0;
            end else begin
                if (wr[c]) wr_ptr <= wr_ptr + 1'b1;
                if (rd[c]) rd_ptr <= rd_ptr + 1'b1;
                if (wr[c] && !rd[c])
                    cnt <= cnt + 1'b1;
                else if (rd[c] && !wr[c])
                    cnt <= cnt - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= SEL_Y;
            overflow <= '0;
        end else begin
            state    <= state_nxt;
            overflow <= overflow | (in_dr & ~wr);
        end
    end

    always_comb begin
        sel_oh  = '0;
        head    = '0;
        sel_cnt = '0;
        unique case (state)
            SEL_Y:  begin sel_oh = 3'b001; head = heads[0]; sel_cnt = cnts[0]; end
            SEL_CB: begin sel_oh = 3'b010; head = heads[1]; sel_cnt = cnts[1]; end
            SEL_CR: begin sel_oh = 3'b100; head = heads[2]; sel_cnt = cnts[2]; end
            default: ;
        endcase
    end

    // Strict MCU order: only a block-ending transfer moves to the next channel
    always_comb begin
        state_nxt = state;
        if (out_valid && out_ready && head[37]) begin
            unique case (state)
                SEL_Y:   state_nxt = SEL_CB;
                SEL_CB:  state_nxt = SEL_CR;
                default: state_nxt = SEL_Y;
            endcase
        end
    end

    assign out_valid     = (sel_cnt != '0);
    assign out_bitstream = out_valid ? head[31:0] : 32'd0;
    assign out_eob       = out_valid & head[37];
    assign out_orc       = out_valid ? head[36:32] : 5'd0;
    assign out_channel   = state;

endmodule

// File: tb/tb_ycc_bitstream_merge.sv
// Directed bench for ycc_bitstream_merge with a queue-based
// reference model checked every cycle.
module tb_ycc_bitstream_merge;

    localparam int DEPTH = 8;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic [2:0]  dr = '0, be = '0;
    logic [31:0] dat [3];
    logic [4:0]  orc [3];
    logic        out_ready = 1'b0;

    logic [31:0] out_bitstream;
    logic        out_valid, out_eob;
    logic [4:0]  out_orc;
    logic [1:0]  out_channel;
    logic [2:0]  overflow;

    ycc_bitstream_merge #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .y_bitstream(dat[0]), .y_data_ready(dr[0]),
        .y_block_end(be[0]), .y_orc(orc[0]),
        .cb_bitstream(dat[1]), .cb_data_ready(dr[1]),
        .cb_block_end(be[1]), .cb_orc(orc[1]),
        .cr_bitstream(dat[2]), .cr_data_ready(dr[2]),
        .cr_block_end(be[2]), .cr_orc(orc[2]),
        .out_bitstream(out_bitstream), .out_valid(out_valid),
        .out_ready(out_ready), .out_eob(out_eob),
        .out_orc(out_orc), .out_channel(out_channel),
        .overflow(overflow)
    );

    typedef struct {
        logic [31:0] d;
        logic        e;
        logic [4:0]  o;
    } ent_t;

    ent_t        q [3][$];
    int          st = 0;
    logic [2:0]  movf = '0;
    logic [39:0] xlog [$];
    int          n_chk = 0, n_fail = 0;

    task automatic chk(input string name, input logic [39:0] act, input logic [39:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: compare on negedge, advance on posedge
    always begin
        @(negedge clk);
        if (!rst) begin
            for (int c = 0; c < 3; c++) q[c].delete();
            st   = 0;
            movf = '0;
            chk("rst_valid", {39'd0, out_valid}, 40'd0);
            chk("rst_data", {8'd0, out_bitstream}, 40'd0);
            chk("rst_eob_orc", {34'd0, out_eob, out_orc}, 40'd0);
            chk("rst_ch_ovf", {35'd0, out_channel, overflow}, 40'd0);
        end else begin
            logic ev;
            ev = (q[st].size() != 0);
            chk("valid", {39'd0, out_valid}, {39'd0, ev});
            chk("channel", {38'd0, out_channel}, 40'(st));
            chk("overflow", {37'd0, overflow}, {37'd0, movf});
            if (ev) begin
                chk("data", {8'd0, out_bitstream}, {8'd0, q[st][0].d});
                chk("eob", {39'd0, out_eob}, {39'd0, q[st][0].e});
                chk("orc", {35'd0, out_orc}, {35'd0, q[st][0].o});
            end else begin
                chk("idle_fields", {2'd0, out_eob, out_orc, out_bitstream}, 40'd0);
            end
            if (out_valid && out_ready)
                xlog.push_back({out_channel, out_eob, out_orc, out_bitstream});
        end
        @(posedge clk);
        if (rst) begin
            int   sz [3];
            int   stb;
            logic xfer;
            ent_t e;
            for (int c = 0; c < 3; c++) sz[c] = q[c].size();
            stb  = st;
            xfer = (sz[st] != 0) && out_ready;
            if (xfer) begin
                e = q[st].pop_front();
                if (e.e) st = (st + 1) % 3;
            end
            for (int c = 0; c < 3; c++) begin
                if (dr[c]) begin
                    if (sz[c] < DEPTH || (xfer && stb == c)) begin
                        e.d = dat[c];
                        e.e = be[c];
                        e.o = be[c] ? orc[c] : 5'd0;
                        q[c].push_back(e);
                    end else begin
                        movf[c] = 1'b1;
                    end
                end
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic put(input int c, input logic [31:0] d, input logic e, input logic [4:0] o);
        dr[c]  = 1'b1;
        dat[c] = d;
        be[c]  = e;
        orc[c] = o;
    endtask

    task automatic w1(input int c, input logic [31:0] d, input logic e, input logic [4:0] o);
        put(c, d, e, o);
        tick();
        dr = '0;
        be = '0;
    endtask

    logic [39:0] exp2 [6];

    initial begin
        for (int c = 0; c < 3; c++) begin
            dat[c] = '0;
            orc[c] = '0;
        end
        repeat (3) tick();
        rst = 1'b1;
        tick();

        // MCU ordering with Cr/Cb arriving before Y
        out_ready = 1'b1;
        xlog.delete();
        w1(2, 32'hC000_0001, 1'b0, 5'd0);
        w1(2, 32'hC000_0002, 1'b1, 5'd5);
        w1(1, 32'hB000_0001, 1'b1, 5'd0);
        w1(0, 32'hA000_0001, 1'b0, 5'd9);
        w1(0, 32'hA000_0002, 1'b0, 5'd0);
        w1(0, 32'hA000_0003, 1'b1, 5'd17);
        repeat (8) tick();
        exp2[0] = {2'd0, 1'b0, 5'd0,  32'hA000_0001};
        exp2[1] = {2'd0, 1'b0, 5'd0,  32'hA000_0002};
        exp2[2] = {2'd0, 1'b1, 5'd17, 32'hA000_0003};
        exp2[3] = {2'd1, 1'b1, 5'd0,  32'hB000_0001};
        exp2[4] = {2'd2, 1'b0, 5'd0,  32'hC000_0001};
        exp2[5] = {2'd2, 1'b1, 5'd5,  32'hC000_0002};
        chk("order_len", 40'(xlog.size()), 40'd6);
        for (int i = 0; i < 6; i++)
            if (i < xlog.size()) chk($sformatf("order_%0d", i), xlog[i], exp2[i]);

        // Backpressure
        out_ready = 1'b0;
        w1(0, 32'h1111_0001, 1'b0, 5'd0);
        w1(0, 32'h1111_0002, 1'b1, 5'd3);
        tick();
        chk("bp_start", {8'd0, out_bitstream}, 40'h0011110001);
        repeat (10) tick();
        chk("bp_hold", {8'd0, out_bitstream}, 40'h0011110001);
        out_ready = 1'b1;
        tick();
        chk("bp_first_xfer", {8'd0, out_bitstream}, 40'h0011110002);
        tick();
        chk("bp_to_cb", {38'd0, out_channel}, 40'd1);
        w1(1, 32'hB000_0010, 1'b1, 5'd1);
        w1(2, 32'hC000_0010, 1'b1, 5'd2);
        repeat (4) tick();
        chk("bp_back_y", {38'd0, out_channel}, 40'd0);

        // Overflow on unselected Cb
        for (int i = 0; i < DEPTH + 2; i++)
            w1(1, 32'hBB00_0000 + 32'(i), (i == DEPTH - 1), 5'd4);
        chk("ovf_set", {37'd0, overflow}, 40'd2);
        w1(0, 32'hA000_00A5, 1'b1, 5'd1);
        repeat (DEPTH + 4) tick();
        w1(2, 32'hC000_00C5, 1'b1, 5'd1);
        repeat (4) tick();
        chk("ovf_sticky", {37'd0, overflow}, 40'd2);

        // Reset mid-traffic
        out_ready = 1'b0;
        w1(0, 32'hA000_0007, 1'b0, 5'd0);
        w1(0, 32'hA000_0008, 1'b0, 5'd0);
        chk("pre_rst_valid", {39'd0, out_valid}, 40'd1);
        rst = 1'b0;
        #1;
        chk("rst_async", {out_valid, out_eob, out_orc, out_bitstream}, 40'd0);
        chk("rst_async_ovf", {37'd0, overflow}, 40'd0);
        tick();
        tick();
        rst = 1'b1;
        tick();
        chk("post_rst_empty", {39'd0, out_valid}, 40'd0);
        repeat (3) tick();
        chk("post_rst_idle", {39'd0, out_valid}, 40'd0);

        // Full FIFO accepts a write on the same edge as a read
        for (int i = 0; i < DEPTH; i++)
            w1(0, 32'hD000_0000 + 32'(i), 1'b0, 5'd7);
        chk("full_head", {8'd0, out_bitstream}, 40'h00D0000000);
        chk("full_no_ovf", {37'd0, overflow}, 40'd0);
        out_ready = 1'b1;
        w1(0, 32'hD000_00FF, 1'b1, 5'd6);
        chk("full_rw_ovf", {37'd0, overflow}, 40'd0);
        repeat (DEPTH + 3) tick();
        w1(1, 32'hB000_0020, 1'b1, 5'd0);
        w1(2, 32'hC000_0020, 1'b1, 5'd0);
        repeat (4) tick();

        // Pointer wrap with interleaved single-word blocks
        for (int i = 0; i < 3 * DEPTH; i++) begin
            put(0, 32'hE000_0000 + 32'(i), 1'b1, 5'(i));
            put(1, 32'hE100_0000 + 32'(i), 1'b1, 5'(i + 1));
            put(2, 32'hE200_0000 + 32'(i), 1'b1, 5'(i + 2));
            out_ready = 1'b1;
            tick();
            dr = '0;
            be = '0;
            if (i == 0) begin
                chk("wrap_first_valid", {39'd0, out_valid}, 40'd1);
                chk("wrap_first_data", {8'd0, out_bitstream}, 40'h00E0000000);
            end
            for (int k = 0; k < 4; k++) begin
                out_ready = (k != 2);
                tick();
            end
        end
        out_ready = 1'b1;
        repeat (10) tick();
        chk("drained", {39'd0, out_valid}, 40'd0);
        chk("drained_ch", {38'd0, out_channel}, 40'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
